// File: rtl/tron_player_motion_if.sv
// tron_player_motion_if: control inputs and position/status outputs of one TRON player.
interface tron_player_motion_if;
  logic start, btn_up, btn_down, btn_left, btn_right, dead_in;
  logic [9:0] x, y;
  logic [1:0] dir;
  logic moved, wall_hit, running;
  modport master(output start, btn_up, btn_down, btn_left, btn_right, dead_in,
                 input x, y, dir, moved, wall_hit, running);
  modport slave(input start, btn_up, btn_down, btn_left, btn_right, dead_in,
                output x, y, dir, moved, wall_hit, running);
endinterface

// File: rtl/tron_player_motion.sv
// tron_player_motion: latches heading requests and steps the player one grid cell per game tick.
module tron_player_motion #(
  parameter int TICK_DIV = 1_000_000,
  parameter int GRID_W = 160,
  parameter int GRID_H = 120,
  parameter int X_INIT = 40,
  parameter int Y_INIT = 60,
  parameter logic [1:0] DIR_INIT = 2'd3
) (
  input logic clk,
  input logic reset,
  tron_player_motion_if.slave io
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [9:0] XMAX = 10'(GRID_W - 1);
  localparam logic [9:0] YMAX = 10'(GRID_H - 1);
  localparam logic [9:0] XI = 10'(X_INIT);
  localparam logic [9:0] YI = 10'(Y_INIT);
  state_t state, state_n;
  logic [CW-1:0] tick_cnt;
  logic [1:0] pending, req;
  logic [9:0] nx, ny;
  logic run, btn, tick, wall;
  assign io.running = run;
  always_comb begin
    run = state == RUN;
    btn = io.btn_up | io.btn_down | io.btn_left | io.btn_right;
    req = io.btn_up ? 2'd0 : io.btn_down ? 2'd1 : io.btn_left ? 2'd2 : 2'd3;
    tick = run && tick_cnt == CW'(TICK_DIV - 1);
    nx = pending == 2'd2 ? io.x - 10'd1 : pending == 2'd3 ? io.x + 10'd1 : io.x;
    ny = pending == 2'd0 ? io.y - 10'd1 : pending == 2'd1 ? io.y + 10'd1 : io.y;
    wall = pending == 2'd0 ? io.y == 10'd0 : pending == 2'd1 ? io.y == YMAX :
           pending == 2'd2 ? io.x == 10'd0 : io.x == XMAX;
    state_n = io.start ? RUN : run && (io.dead_in || io.wall_hit) ? HALT : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      io.x <= XI;
      io.y <= YI;
      io.dir <= DIR_INIT;
      pending <= DIR_INIT;
      tick_cnt <= '0;
      io.moved <= 1'b0;
      io.wall_hit <= 1'b0;
    end else begin
      io.moved <= 1'b0;
      if (io.start) begin
        io.x <= XI;
        io.y <= YI;
        io.dir <= DIR_INIT;
        pending <= DIR_INIT;
        tick_cnt <= '0;
        io.wall_hit <= 1'b0;
      end else if (run && !io.dead_in) begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        // reversal is judged against the heading actually travelled, not the pending one
        if (btn && req != (io.dir ^ 2'd1)) pending <= req;
        if (tick) begin
          io.dir <= pending;
          if (wall) io.wall_hit <= 1'b1;
          else begin
            io.x <= nx;
            io.y <= ny;
            io.moved <= 1'b1;
          end
        end
      end else tick_cnt <= '0;
    end
endmodule

// File: tb/tb_tron_player_motion.sv
// tb_tron_player_motion: directed vector table plus wall, dead/start and reset sequences.
module tb_tron_player_motion;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  tron_player_motion_if io();
  tron_player_motion #(.TICK_DIV(8)) dut(.clk(clk), .reset(reset), .io(io.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic st, up, dn, lf, rt, dd;
    int w;
    logic [9:0] x, y;
    logic [1:0] d;
    logic mv, wh, rn;
  } vec_t;
  vec_t v[14];
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [9:0] a, input logic [9:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask
  task automatic chk_all(input string t, input logic [9:0] ex, ey, input logic [1:0] ed,
                         input logic emv, ewh, ern);
    chk({t, ".x"}, io.x, ex);
    chk({t, ".y"}, io.y, ey);
    chk({t, ".dir"}, 10'(io.dir), 10'(ed));
    chk({t, ".moved"}, 10'(io.moved), 10'(emv));
    chk({t, ".wall_hit"}, 10'(io.wall_hit), 10'(ewh));
    chk({t, ".running"}, 10'(io.running), 10'(ern));
  endtask
  task automatic drive(input logic st, up, dn, lf, rt, dd);
    io.start = st;
    io.btn_up = up;
    io.btn_down = dn;
    io.btn_left = lf;
    io.btn_right = rt;
    io.dead_in = dd;
  endtask
  function automatic vec_t mk(input logic st, up, dn, lf, rt, dd, input int w,
                              input int x, y, input logic [1:0] d, input logic mv, wh, rn);
    vec_t r;
    r.st = st; r.up = up; r.dn = dn; r.lf = lf; r.rt = rt; r.dd = dd; r.w = w;
    r.x = 10'(x); r.y = 10'(y); r.d = d; r.mv = mv; r.wh = wh; r.rn = rn;
    return r;
  endfunction
  initial begin
    logic any_mv;
    v[0]  = mk(1, 0, 0, 0, 0, 0, 1, 40, 60, 3, 0, 0, 1);
    v[1]  = mk(0, 0, 0, 0, 0, 0, 8, 41, 60, 3, 1, 0, 1);
    v[2]  = mk(0, 0, 0, 0, 0, 0, 1, 41, 60, 3, 0, 0, 1);
    v[3]  = mk(0, 0, 0, 0, 0, 0, 7, 42, 60, 3, 1, 0, 1);
    v[4]  = mk(0, 0, 0, 1, 0, 0, 8, 43, 60, 3, 1, 0, 1);
    v[5]  = mk(0, 1, 0, 0, 0, 0, 1, 43, 60, 3, 0, 0, 1);
    v[6]  = mk(0, 0, 0, 1, 0, 0, 7, 43, 59, 0, 1, 0, 1);
    v[7]  = mk(0, 0, 0, 0, 1, 0, 8, 44, 59, 3, 1, 0, 1);
    v[8]  = mk(0, 0, 1, 1, 0, 0, 8, 44, 60, 1, 1, 0, 1);
    v[9]  = mk(0, 0, 0, 0, 0, 0, 7, 44, 60, 1, 0, 0, 1);
    v[10] = mk(0, 0, 0, 0, 0, 1, 1, 44, 60, 1, 0, 0, 0);
    v[11] = mk(0, 0, 0, 0, 0, 0, 10, 44, 60, 1, 0, 0, 0);
    v[12] = mk(0, 1, 0, 0, 0, 0, 9, 44, 60, 1, 0, 0, 0);
    v[13] = mk(1, 0, 0, 0, 0, 0, 1, 40, 60, 3, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    step(2);
    chk_all("reset", 40, 60, 3, 0, 0, 0);
    reset = 1'b0;
    step(3);
    chk_all("idle", 40, 60, 3, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      drive(v[i].st, v[i].up, v[i].dn, v[i].lf, v[i].rt, v[i].dd);
      step(1);
      drive(0, 0, 0, 0, 0, 0);
      if (v[i].w > 1) step(v[i].w - 1);
      chk_all($sformatf("v%0d", i), v[i].x, v[i].y, v[i].d, v[i].mv, v[i].wh, v[i].rn);
    end
    step(952);
    chk_all("edge", 159, 60, 3, 1, 0, 1);
    step(8);
    chk_all("wall", 159, 60, 3, 0, 1, 1);
    step(1);
    chk_all("wall_halt", 159, 60, 3, 0, 1, 0);
    step(10);
    chk_all("wall_frozen", 159, 60, 3, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1);
    step(1);
    drive(0, 0, 0, 0, 0, 0);
    chk_all("start_dead", 40, 60, 3, 0, 0, 1);
    step(8);
    chk_all("after_start", 41, 60, 3, 1, 0, 1);
    step(3);
    #2 reset = 1'b1;
    #1 chk_all("async_reset", 40, 60, 3, 0, 0, 0);
    step(1);
    reset = 1'b0;
    any_mv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      any_mv |= io.moved;
    end
    chk("post_reset.moved", 10'(any_mv), 10'd0);
    chk_all("post_reset", 40, 60, 3, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
